// File: rtl/down_timer.sv
// Loadable down-counting timer with terminal-count pulse and optional auto-reload.
// Used as a programmable delay or periodic tick source; tc marks each expiry.
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld,
  input  logic             dec,
  input  logic             reload_en,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  // state | meaning
  // IDLE  | nothing loaded (or zero loaded); dec ignored
  // ARMED | nonzero value loaded, waiting for first dec
  // RUN   | counting; dec=0 pauses
  // DONE  | expired without reload; q held at 0
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           st, st_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [WIDTH-1:0] reload_r, reload_nxt;
  logic             tc_r, tc_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= IDLE;
      q_r      <= '0;
      reload_r <= '0;
      tc_r     <= 1'b0;
    end else begin
      st       <= st_nxt;
      q_r      <= q_nxt;
      reload_r <= reload_nxt;
      tc_r     <= tc_nxt;
    end
  end

  always_comb begin
    st_nxt     = st;
    q_nxt      = q_r;
    reload_nxt = reload_r;
    tc_nxt     = 1'b0;
    if (ld) begin
      q_nxt      = data_in;
      reload_nxt = data_in;
      st_nxt     = (data_in != '0) ? ARMED : IDLE;
    end else begin
      case (st)
        ARMED, RUN: begin
          // q==0 cannot occur here; the guard keeps the counter from ever wrapping
          if (dec && q_r != '0) begin
            if (q_r == WIDTH'(1)) begin
              tc_nxt = 1'b1;
              if (reload_en) begin
                q_nxt  = reload_r;
                st_nxt = RUN;
              end else begin
                q_nxt  = '0;
                st_nxt = DONE;
              end
            end else begin
              q_nxt  = q_r - WIDTH'(1);
              st_nxt = RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign q     = q_r;
  assign tc    = tc_r;
  assign busy  = (st == RUN);
  assign done  = (st == DONE);
  assign state = st;

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: directed test-plan steps followed by random stimulus,
// all checked against a behavioural model of the timer.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       ld, dec, reload_en;
  logic [7:0] q;
  logic       tc, busy, done;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // model: remaining count, period, phase (0 idle, 1 armed, 2 run, 3 done), tick
  int m_q, m_rl, m_ph, m_tc;

  down_timer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .ld(ld), .dec(dec),
    .reload_en(reload_en), .q(q), .tc(tc), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_rl = 0; m_ph = 0; m_tc = 0;
  endtask

  task automatic model_edge(input bit l, input int d, input bit de, input bit re);
    m_tc = 0;
    if (l) begin
      m_q = d; m_rl = d; m_ph = (d != 0) ? 1 : 0;
    end else if (de && (m_ph == 1 || m_ph == 2)) begin
      if (m_q == 1) begin
        m_tc = 1;
        m_q  = re ? m_rl : 0;
        m_ph = re ? 2 : 3;
      end else begin
        m_q  = m_q - 1;
        m_ph = 2;
      end
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q"}, int'(q), m_q);
    chk({tag, ".state"}, int'(state), m_ph);
    chk({tag, ".tc"}, int'(tc), m_tc);
    chk({tag, ".busy"}, int'(busy), int'(m_ph == 2));
    chk({tag, ".done"}, int'(done), int'(m_ph == 3));
  endtask

  // called at a falling edge: drive, let one rising edge happen, check at next falling edge
  task automatic step(input string tag, input bit l, input int d, input bit de, input bit re);
    ld = l; data_in = d[7:0]; dec = de; reload_en = re;
    @(posedge clk);
    model_edge(l, d, de, re);
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    rst = 1'b0; ld = 0; dec = 0; reload_en = 0; data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all("reset");
    rst = 1'b1;

    // count to expiry
    step("exp_ld", 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) step("exp_dec", 0, 0, 1, 0);
    chk("exp_q_end", int'(q), 0);
    chk("exp_done_end", int'(done), 1);

    // auto-reload with period 2
    step("rl_ld", 1, 2, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step("rl_dec", 0, 0, 1, 1);
      chk("rl_tc_pattern", int'(tc), int'(i % 2 == 1));
      chk("rl_state", int'(state), 2);
    end

    // ld/dec collision
    step("col_ld", 1, 6, 0, 0);
    step("col_dec", 0, 0, 1, 0);
    step("col_hit", 1, 8'hA0, 1, 0);
    chk("col_q", int'(q), 8'hA0);
    chk("col_state", int'(state), 1);

    // zero load, no underflow
    step("zero_ld", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("zero_dec", 0, 0, 1, 1);
    chk("zero_no_wrap", int'(q), 0);

    // pause, then one-shot of 1
    step("pause_ld", 1, 5, 0, 0);
    step("pause_dec", 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("pause_hold", 0, 0, 0, 0);
    chk("pause_q", int'(q), 4);
    chk("pause_busy", int'(busy), 1);
    step("one_ld", 1, 1, 1, 0);
    step("one_dec", 0, 0, 1, 0);
    chk("one_tc", int'(tc), 1);
    chk("one_state", int'(state), 3);
    step("one_after", 0, 0, 1, 0);

    // async reset mid-run, checked before any clock edge
    step("ar_ld", 1, 5, 0, 0);
    step("ar_dec", 0, 0, 1, 0);
    #2 rst = 1'b0;
    model_reset();
    #1 chk_all("ar_async");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step("ar_post", 0, 0, 1, 0);

    // random stimulus
    for (int i = 0; i < 400; i++) begin
      bit l, de, re;
      int d;
      l  = ($urandom_range(0, 9) == 0);
      de = ($urandom_range(0, 4) != 0);
      re = $urandom_range(0, 1);
      d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
      step("rand", l, d, de, re);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting timer with terminal-count detection and optional auto-reload. It is the decrementing counterpart to the team's loadable up-counter and shares its load/enable command style: `ld` loads `data_in`, and a count enable steps the value, here downward. Downstream logic uses it as a programmable delay or periodic tick source, with `tc` as the event output.

## Interface
- `WIDTH`, default 8, width of `data_in`, `q` and the internal reload register.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data_in`  in  WIDTH  load value, sampled when `ld`=1.
- `ld`  in  1  load command; highest priority after reset.
- `dec`  in  1  count enable; decrement by 1 per cycle when allowed.
- `reload_en`  in  1  auto-reload when the count expires; sampled on the expiring edge.
- `q`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal-count pulse, one cycle wide, registered.
- `busy`  out  1  high while state = RUN.
- `done`  out  1  high while state = DONE.
- `state`  out  2  FSM state: IDLE=00, ARMED=01, RUN=10, DONE=11.

## Operation
- Reset (`rst`=0, any time, no clock needed):
  - `q`, reload register, `tc`, `busy` and `done` go to 0.
  - `state` goes to IDLE.
  - Any operation in progress is abandoned.
- Priority each edge: reset > `ld` > `dec`.
- `ld`=1 in any state:
  - `q` <= `data_in` and reload register <= `data_in`.
  - `state` <= ARMED if `data_in` != 0, else IDLE.
  - `tc` <= 0; `dec` in the same cycle is ignored.
- IDLE: `dec` ignored and `q` holds.
- ARMED: `dec`=1 decrements `q` and moves to RUN.
- RUN, `dec`=0: `q` holds and the state stays RUN (pause).
- RUN or ARMED, `dec`=1 and `q` > 1: `q` <= `q`-1.
- RUN or ARMED, `dec`=1 and `q` = 1 (expiring edge):
  - `tc` <= 1 in both cases.
  - With `reload_en`=1: `q` <= reload register (0 is skipped) and the state goes to RUN.
  - With `reload_en`=0: `q` <= 0 and the state goes to DONE.
- DONE: `q` holds 0 and `dec` is ignored; only `ld` or reset leaves DONE.
- `tc` is 0 on every edge that is not an expiring edge.
- Underflow is impossible: no state decrements from 0, and `q` never wraps to all-ones.
- Arithmetic is unsigned WIDTH-bit.
- Auto-reload period equals the reload value N, giving one `tc` every N enabled cycles. With N=1, `tc` is high on every enabled cycle.

## Timing
- Inputs are sampled on the rising edge of `clk`. Benches drive on the falling edge and check on the falling edge.
- Latency: `ld` or `dec` affects `q` and `state` at the next rising edge (1 cycle).
- `tc` goes high in the cycle after the expiring edge. That is the same cycle `q` shows 0 (no reload) or the reload value (reload). It stays high for exactly one cycle unless the next edge is also an expiring edge.
- `busy` and `done` are decoded from the registered state, so they have the same 1-cycle latency as `state`.
- Deasserting reset has no effect until the next rising edge. The first edge after release can accept `ld`.

## Test plan
- **Async reset:** in RUN with `q`=8'h04, drive `rst`=0 between edges -> `q`=0, `state`=00, `tc`=`busy`=`done`=0 immediately. After release, `dec`=1 for 3 cycles -> `q` stays 0.
- **Count to expiry:** `ld` with `data_in`=8'h03, then `dec`=1 for 5 cycles with `reload_en`=0 -> `q` goes 3,2,1,0,0,0. `tc` is high only in the cycle where `q` first reads 0. `state` goes 01,10,10,11; `done`=1 at the end.
- **Auto-reload:** `ld` with `data_in`=8'h02, `reload_en`=1, `dec`=1 for 6 cycles -> `q` goes 2,1,2,1,2,1,2. `tc` is high in the three cycles where `q` returns to 2. `state` stays 10 throughout.
- **ld/dec collision:** in RUN with `q`=8'h05, `ld`=1, `dec`=1, `data_in`=8'hA0 -> `q`=8'hA0, `state`=01, `tc`=0, no decrement.
- **Zero load and no underflow:** `ld` with `data_in`=0 -> `q`=0, `state`=00. Then `dec`=1 for 4 cycles -> `q` stays 0 (never 8'hFF) and `tc` stays 0.
- **Pause and one-shot of 1:**
  - In RUN with `q`=8'h04, `dec`=0 for 3 cycles -> `q` holds 4 and `busy`=1.
  - Then `ld` with `data_in`=8'h01, `dec`=1, `reload_en`=0 -> `q`=0, `tc` pulses once, `state`=11.
